// File: rtl/uart_rx_stream.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_stream
// Purpose  : 8N1 UART receiver feeding a first-word-fall-through byte FIFO
//            with a valid/ready output stream.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_stream #(
    parameter int CLKS_PER_BIT    = 417,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       framing_error,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] c_full      = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_e;

    logic                        rx_meta_q, rx_s_q;
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic [7:0]                  shift_q, shift_d;
    logic                        fe_q, fe_d;
    logic                        ov_q, ov_d;
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic [7:0]                  mem_q [DEPTH];
    logic [7:0]                  mem_d [DEPTH];
    logic                        w_push, w_pop, w_full, w_wr;

    // Receiver state machine
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        w_push    = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        w_push  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        w_pop    = (level_q != '0) && out_ready;
        w_full   = (level_q == c_full);
        w_wr     = w_push && (!w_full || w_pop);
        ov_d     = w_push && w_full && !w_pop;
        wr_ptr_d = w_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (w_wr && !w_pop)      level_d = level_q + LVL_W'(1);
        else if (!w_wr && w_pop) level_d = level_q - LVL_W'(1);
        mem_d = mem_q;
        if (w_wr) mem_d[wr_ptr_q] = shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // Storage needs no reset: level and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_data      = mem_q[rd_ptr_q];
    assign out_valid     = (level_q != '0);
    assign framing_error = fe_q;
    assign overflow      = ov_q;
    assign fifo_level    = level_q;

endmodule
`default_nettype wire
